// File: rtl/router_ingress_if.sv
// Source-port byte stream plus write side of the three destination FIFOs.
// master = packet source / FIFO bank, slave = router_ingress.
interface router_ingress_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_DEST = 3
);
    logic                pkt_valid;
    logic [DATA_W-1:0]   data_in;
    logic                busy;
    logic [NUM_DEST-1:0] fifo_full;
    logic [NUM_DEST-1:0] fifo_empty;
    logic [NUM_DEST-1:0] soft_reset;
    logic [DATA_W-1:0]   dout;
    logic [NUM_DEST-1:0] write_enb;
    logic                lfd_state;
    logic                parity_done;
    logic                err;
    logic                pkt_drop;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        input  busy, dout, write_enb, lfd_state, parity_done, err, pkt_drop
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        output busy, dout, write_enb, lfd_state, parity_done, err, pkt_drop
    );
endinterface

// File: rtl/router_ingress.sv
// Router ingress: parses header/payload/parity bytes, stages each byte in a
// one-entry hold register and writes it to the addressed FIFO.
module router_ingress #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_DEST = 3
) (
    input logic            clk,
    input logic            reset,
    router_ingress_if.slave bus
);
    localparam int unsigned AW = 2;
    localparam int unsigned LW = DATA_W - AW;
    localparam int unsigned RW = LW + 1;

    typedef enum logic [2:0] {IDLE, WAIT_EMPTY, PAYLOAD, PARITY, DROP} state_e;

    state_e            state_q, state_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_byte_q, hold_byte_d;
    logic [AW-1:0]     hold_addr_q, hold_addr_d;
    logic              hold_hdr_q, hold_hdr_d;
    logic [AW-1:0]     pkt_addr_q, pkt_addr_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0] par_q, par_d;
    logic              err_q, err_d;
    logic              parity_done_q, parity_done_d;
    logic              pkt_drop_q, pkt_drop_d;

    logic          in_pkt, abort, kill_hold, can_write, busy, accept;
    logic          load_hold, load_hdr;
    logic [AW-1:0] hdr_addr;
    logic [LW-1:0] hdr_len;

    assign hdr_addr  = bus.data_in[AW-1:0];
    assign hdr_len   = bus.data_in[DATA_W-1:AW];
    assign in_pkt    = (state_q == WAIT_EMPTY) || (state_q == PAYLOAD) || (state_q == PARITY);
    assign abort     = in_pkt & bus.soft_reset[pkt_addr_q];
    // Outside a packet a soft reset still discards a byte staged for that FIFO.
    assign kill_hold = hold_valid_q & (abort | bus.soft_reset[hold_addr_q]);
    assign can_write = hold_valid_q & ~bus.fifo_full[hold_addr_q]
                     & (state_q != WAIT_EMPTY) & ~kill_hold;
    assign busy      = (state_q == WAIT_EMPTY) | (hold_valid_q & ~can_write);
    assign accept    = bus.pkt_valid & ~busy;

    assign bus.busy        = busy;
    assign bus.err         = err_q;
    assign bus.parity_done = parity_done_q;
    assign bus.pkt_drop    = pkt_drop_q;

    always_comb begin
        bus.write_enb = '0;
        bus.dout      = '0;
        bus.lfd_state = 1'b0;
        if (can_write) begin
            bus.write_enb[hold_addr_q] = 1'b1;
            bus.dout                   = hold_byte_q;
            bus.lfd_state              = hold_hdr_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_valid_d  = hold_valid_q & ~can_write & ~kill_hold;
        hold_byte_d   = hold_byte_q;
        hold_addr_d   = hold_addr_q;
        hold_hdr_d    = hold_hdr_q;
        pkt_addr_d    = pkt_addr_q;
        rem_d         = rem_q;
        par_d         = par_q;
        err_d         = err_q;
        parity_done_d = 1'b0;
        pkt_drop_d    = 1'b0;
        load_hold     = 1'b0;
        load_hdr      = 1'b0;

        if (abort) begin
            // Remaining payload plus parity is discarded; a byte taken this cycle counts.
            rem_d      = rem_q + RW'(1) - RW'(accept);
            state_d    = (rem_d == '0) ? IDLE : DROP;
            pkt_drop_d = 1'b1;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    err_d = 1'b0;
                    par_d = bus.data_in;
                    rem_d = RW'(hdr_len);
                    if (hdr_addr == AW'(NUM_DEST)) begin
                        rem_d      = RW'(hdr_len) + RW'(1);
                        state_d    = DROP;
                        pkt_drop_d = 1'b1;
                    end else begin
                        load_hold  = 1'b1;
                        load_hdr   = 1'b1;
                        pkt_addr_d = hdr_addr;
                        if (bus.fifo_empty[hdr_addr]) begin
                            state_d = (hdr_len == '0) ? PARITY : PAYLOAD;
                        end else begin
                            state_d = WAIT_EMPTY;
                        end
                    end
                end
                PAYLOAD: begin
                    load_hold = 1'b1;
                    par_d     = par_q ^ bus.data_in;
                    rem_d     = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    load_hold     = 1'b1;
                    err_d         = (bus.data_in != par_q);
                    parity_done_d = 1'b1;
                    state_d       = IDLE;
                end
                DROP: begin
                    rem_d = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end else if ((state_q == WAIT_EMPTY) && bus.fifo_empty[pkt_addr_q]) begin
            state_d = (rem_q == '0) ? PARITY : PAYLOAD;
        end

        if (load_hold) begin
            hold_valid_d = 1'b1;
            hold_byte_d  = bus.data_in;
            hold_addr_d  = load_hdr ? hdr_addr : pkt_addr_q;
            hold_hdr_d   = load_hdr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_valid_q  <= 1'b0;
            hold_byte_q   <= '0;
            hold_addr_q   <= '0;
            hold_hdr_q    <= 1'b0;
            pkt_addr_q    <= '0;
            rem_q         <= '0;
            par_q         <= '0;
            err_q         <= 1'b0;
            parity_done_q <= 1'b0;
            pkt_drop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_valid_q  <= hold_valid_d;
            hold_byte_q   <= hold_byte_d;
            hold_addr_q   <= hold_addr_d;
            hold_hdr_q    <= hold_hdr_d;
            pkt_addr_q    <= pkt_addr_d;
            rem_q         <= rem_d;
            par_q         <= par_d;
            err_q         <= err_d;
            parity_done_q <= parity_done_d;
            pkt_drop_q    <= pkt_drop_d;
        end
    end
endmodule

// File: doc/router_ingress.md
Name: router_ingress

Overview:
- Packet ingress stage of the router. It accepts the serial byte stream from the source port and parses each packet's header, payload and parity byte.
- It drives one of three downstream router_fifo instances: dout, per-FIFO write_enb, and lfd_state on the header write.
- It applies byte-level backpressure to the source, checks packet parity, and discards misaddressed or aborted packets.

Parameters:
- DATA_W, 8, byte width; header layout below assumes 8.
- NUM_DEST, 3, number of destination FIFOs; address value NUM_DEST is invalid.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pkt_valid  in  1  data_in holds a valid byte
- data_in  in  8  packet byte
- busy  out  1  backpressure; byte accepted iff pkt_valid=1 and busy=0 at the clock edge
- fifo_full  in  3  full flag of each destination FIFO
- fifo_empty  in  3  empty flag of each destination FIFO
- soft_reset  in  3  per-FIFO soft reset; aborts a packet in progress to that FIFO
- dout  out  8  byte to FIFO
- write_enb  out  3  one-hot FIFO write strobe
- lfd_state  out  1  high with write_enb when dout is a header
- parity_done  out  1  1-cycle pulse after the parity byte is accepted
- err  out  1  parity mismatch on last packet; held until next header accepted
- pkt_drop  out  1  1-cycle pulse when a packet is discarded (bad address or abort)

Behaviour:
- Header byte: addr=[1:0], len=[7:2] (0..63 payload bytes). Packet = header + len payload bytes + 1 parity byte.
- Reset values: dout=0, write_enb=0, lfd_state=0, busy=0, parity_done=0, err=0, pkt_drop=0, state=IDLE, hold empty.
- Hold register: single entry {byte, addr, is_hdr}. An accepted byte enters hold at the edge.
- Hold drains when can_write = hold_valid & !fifo_full[hold_addr] & state!=WAIT_EMPTY.
- While can_write: write_enb[hold_addr]=1, dout=hold byte, lfd_state=is_hdr. These are combinational from registered hold state.
- Minimum latency is 1 cycle from the accept edge to the write cycle.
- busy = (state==WAIT_EMPTY) | (hold_valid & !can_write). Hold refills in the same cycle it drains, so throughput is 1 byte/cycle while the FIFO is not full.
- State IDLE, on header accept:
  - Clear err; load parity accumulator with header; rem=len.
  - addr==3: no hold load; rem=len+1; go DROP; pkt_drop=1 next cycle.
  - fifo_empty[addr]=1 at accept: go PAYLOAD, or PARITY if len=0.
  - Otherwise: go WAIT_EMPTY.
- WAIT_EMPTY: header waits in hold. On fifo_empty[addr]=1, go PAYLOAD (or PARITY if len=0); header write starts the following cycle.
- PAYLOAD: each accept does parity^=byte and rem-=1; the accept with rem=1 goes to PARITY.
- PARITY: on accept, err<=(byte != accumulator); parity byte is also written to the FIFO; parity_done=1 next cycle; go IDLE.
- DROP: busy=0; accepted bytes are discarded; rem decrements; the accept with rem=1 goes to IDLE.
- soft_reset[addr] high while state is WAIT_EMPTY, PAYLOAD or PARITY:
  - Hold is invalidated and no write occurs that cycle.
  - rem = remaining payload + 1; go DROP; pkt_drop pulses.
  - soft_reset in IDLE or DROP has no effect, except invalidating a held byte addressed to that FIFO.
- A write is never issued to a FIFO whose full flag is high. A full FIFO stalls the byte in hold, busy rises, and the source holds data_in.
- Reset mid-packet: all state is cleared immediately; the next accepted byte is treated as a header.

Test Plan:
- Basic: packet 0x0D,0x11,0x22,0x33,0x0D to empty FIFO1 back-to-back -> write_enb=3'b010 for 5 consecutive cycles starting 1 cycle after the header accept; lfd_state=1 only on 0x0D header; parity_done pulse; err=0.
- Parity error: same packet with parity 0x0C -> all 5 bytes written; err=1 after parity accept; err clears on next header accept.
- Backpressure: fifo_full[1] rises after 0x11 is written -> busy=1, 0x22 held in hold, no write_enb; full drops -> 0x22,0x33,0x0D written in order, no byte lost or duplicated.
- Wait-empty: header 0x02 (len0, addr2) with fifo_empty[2]=0 -> busy=1, no write; empty rises -> header, then parity 0x02, written with lfd_state on header only.
- Bad address: header 0x0B (len2, addr3) + 3 bytes -> pkt_drop pulse, no write_enb; next packet is parsed normally.
- Abort/reset: soft_reset[1] after 2 payload bytes of a len-3 packet -> pkt_drop pulse; the next 2 bytes are discarded. Separately, reset mid-packet -> all outputs return to 0 asynchronously.
